// File: rtl/mult_accum.sv
// Sums groups of TERMS signed products, rounds half-up back to the operand Q format and
// hands each result downstream over valid/ready. Define MULT_ACCUM_SAT_EN to saturate; otherwise results wrap.
module mult_accum #(
  parameter int IN_W      = 54,
  parameter int OUT_W     = 32,
  parameter int FRAC_BITS = 16,
  parameter int TERMS     = 4,
  parameter int ELEMS     = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [IN_W-1:0]      in_prod,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [OUT_W-1:0]     out_data,
  output logic                        out_sat,
  output logic [$clog2(ELEMS)-1:0]    out_idx
);

  localparam int ACC_W = IN_W + $clog2(TERMS);
  localparam int CNT_W = (TERMS > 1) ? $clog2(TERMS) : 1;
  localparam int IDX_W = $clog2(ELEMS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TERMS - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(ELEMS - 1);
  localparam logic signed [ACC_W:0] HALF =
    {{(ACC_W + 1 - FRAC_BITS){1'b0}}, 1'b1, {(FRAC_BITS - 1){1'b0}}};

  typedef enum logic {S_ACC, S_HOLD} state_t;

  state_t                   r_state, w_state_nxt;
  logic signed [ACC_W-1:0]  r_acc, w_sum;
  logic [CNT_W-1:0]         r_cnt;
  logic signed [OUT_W-1:0]  r_data, w_data;
  logic                     r_sat, w_sat;
  logic [IDX_W-1:0]         r_idx;
  logic                     w_in_hs, w_out_hs, w_last;

  // One extra bit of headroom so adding the rounding constant cannot wrap the accumulator.
  function automatic logic signed [ACC_W:0] rnd(input logic signed [ACC_W-1:0] s);
    logic signed [ACC_W:0] t;
    t = (ACC_W + 1)'(s) + HALF;
    return t >>> FRAC_BITS;
  endfunction

`ifdef MULT_ACCUM_SAT_EN
  localparam logic signed [ACC_W:0] SAT_MAX =
    {{(ACC_W + 2 - OUT_W){1'b0}}, {(OUT_W - 1){1'b1}}};
  localparam logic signed [ACC_W:0] SAT_MIN =
    {{(ACC_W + 2 - OUT_W){1'b1}}, {(OUT_W - 1){1'b0}}};

  // Returns {clamped, value}.
  function automatic logic [OUT_W:0] sat(input logic signed [ACC_W:0] r);
    if (r > SAT_MAX) return {1'b1, 1'b0, {(OUT_W - 1){1'b1}}};
    if (r < SAT_MIN) return {1'b1, 1'b1, {(OUT_W - 1){1'b0}}};
    return {1'b0, r[OUT_W-1:0]};
  endfunction

  logic [OUT_W:0] w_norm;
  assign w_norm = sat(rnd(w_sum));
  assign w_data = w_norm[OUT_W-1:0];
  assign w_sat  = w_norm[OUT_W];
`else
  assign w_data = OUT_W'(rnd(w_sum));
  assign w_sat  = 1'b0;
`endif

  assign w_sum    = r_acc + ACC_W'(in_prod);
  assign w_in_hs  = in_valid && in_ready;
  assign w_out_hs = out_valid && out_ready;
  assign w_last   = (r_cnt == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_ACC;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      S_ACC: begin
        in_ready = 1'b1;
        if (in_valid && w_last) w_state_nxt = S_HOLD;
      end
      S_HOLD: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = S_ACC;
      end
    endcase
  end

  // Accumulate stage: the final term bypasses acc and lands directly in the output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc  <= '0;
      r_cnt  <= '0;
      r_data <= '0;
      r_sat  <= 1'b0;
      r_idx  <= '0;
    end else begin
      if (w_in_hs) begin
        if (w_last) begin
          r_acc  <= '0;
          r_cnt  <= '0;
          r_data <= w_data;
          r_sat  <= w_sat;
        end else begin
          r_acc <= w_sum;
          r_cnt <= r_cnt + 1'b1;
        end
      end
      if (w_out_hs) r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
    end
  end

  assign out_data = r_data;
  assign out_sat  = r_sat;
  assign out_idx  = r_idx;

endmodule

// File: tb/tb_mult_accum.sv
// Directed bench for mult_accum: expected results are queued at issue time and a
// monitor pops and compares them on every output handshake.
module tb_mult_accum;

  logic               clk;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic signed [53:0] in_prod;
  logic               out_valid;
  logic               out_ready;
  logic signed [31:0] out_data;
  logic               out_sat;
  logic [3:0]         out_idx;

  mult_accum dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_prod   (in_prod),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat),
    .out_idx   (out_idx)
  );

  typedef struct packed {
    logic [31:0] d;
    logic        s;
    logic [3:0]  i;
  } exp_t;

  localparam logic signed [53:0] ONE = 54'sh1_0000_0000;
  localparam logic signed [53:0] P46 = 54'sd1 <<< 46;
  localparam logic signed [53:0] N46 = -(54'sd1 <<< 46);
  localparam logic signed [53:0] Z   = 54'sd0;

  exp_t       q[$];
  exp_t       mon_e;
  logic [3:0] exp_idx;
  int         n_chk;
  int         n_err;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after the handshake.
  task automatic send(input logic signed [53:0] p);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_prod  = p;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      n_chk++;
      n_err++;
      $display("FAIL in_ready_timeout: in_ready stayed 0 for %0d cycles, required 1", n);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic group(input logic signed [53:0] p0, input logic signed [53:0] p1,
                       input logic signed [53:0] p2, input logic signed [53:0] p3,
                       input logic [31:0] ed, input logic es);
    q.push_back('{d: ed, s: es, i: exp_idx});
    exp_idx = exp_idx + 4'd1;
    send(p0);
    send(p1);
    send(p2);
    send(p3);
  endtask

  task automatic set_ready(input logic v);
    @(posedge clk);
    #1 out_ready = v;
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL unexpected_result: got data 0x%0h, required no output", out_data);
      end else begin
        mon_e = q.pop_front();
        chk("out_data", 64'($unsigned(out_data)), 64'(mon_e.d));
        chk("out_sat",  64'(out_sat),  64'(mon_e.s));
        chk("out_idx",  64'(out_idx),  64'(mon_e.i));
      end
    end
  end

  initial begin
    int n;
    n_chk     = 0;
    n_err     = 0;
    exp_idx   = 4'd0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_prod   = '0;
    out_ready = 1'b1;

    #12;
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data",  64'($unsigned(out_data)), 64'd0);
    chk("rst_out_sat",   64'(out_sat),   64'd0);
    chk("rst_out_idx",   64'(out_idx),   64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Basic group and one-cycle latency
    q.push_back('{d: 32'h0004_0000, s: 1'b0, i: exp_idx});
    exp_idx = exp_idx + 4'd1;
    send(ONE);
    send(ONE);
    send(ONE);
    chk("lat_before_last", 64'(out_valid), 64'd0);
    send(ONE);
    chk("lat_valid", 64'(out_valid), 64'd1);
    chk("hold_in_ready", 64'(in_ready), 64'd0);

    // Rounding half-up
    group(54'sh8000,  Z, Z, Z, 32'h0000_0001, 1'b0);
    group(-54'sh8000, Z, Z, Z, 32'h0000_0000, 1'b0);
    group(-54'sh8001, Z, Z, Z, 32'hFFFF_FFFF, 1'b0);

    // Saturation limits
`ifdef MULT_ACCUM_SAT_EN
    group(P46, P46, P46, P46, 32'h7FFF_FFFF, 1'b1);
    group(N46, N46, N46, N46, 32'h8000_0000, 1'b1);
    group(54'sh7FFF_FFFF_8000, Z, Z, Z, 32'h7FFF_FFFF, 1'b1);
`else
    group(P46, P46, P46, P46, 32'h0000_0000, 1'b0);
    group(N46, N46, N46, N46, 32'h0000_0000, 1'b0);
    group(54'sh7FFF_FFFF_8000, Z, Z, Z, 32'h8000_0000, 1'b0);
`endif
    group(54'sh7FFF_FFFF_0000, Z, Z, Z, 32'h7FFF_FFFF, 1'b0);

    // Backpressure
    set_ready(1'b0);
    group(ONE, ONE, ONE, ONE, 32'h0004_0000, 1'b0);
    for (int k = 0; k < 5; k++) begin
      chk("bp_out_valid", 64'(out_valid), 64'd1);
      chk("bp_in_ready",  64'(in_ready),  64'd0);
      chk("bp_out_data",  64'($unsigned(out_data)), 64'h0004_0000);
      @(negedge clk);
    end
    set_ready(1'b1);
    @(negedge clk);
    chk("bp_release_valid", 64'(out_valid), 64'd0);
    chk("bp_release_ready", 64'(in_ready),  64'd1);

    // Index wrap from a clean reset
    #1 rst = 1'b1;
    #2 rst = 1'b0;
    exp_idx = 4'd0;
    @(negedge clk);
    for (int g = 0; g < 17; g++) group(ONE, ONE, ONE, ONE, 32'h0004_0000, 1'b0);

    // Reset while a result is pending
    set_ready(1'b0);
    group(ONE, ONE, ONE, ONE, 32'h0004_0000, 1'b0);
    #1 rst = 1'b1;
    #1;
    chk("rst_hold_out_valid", 64'(out_valid), 64'd0);
    chk("rst_hold_in_ready",  64'(in_ready),  64'd1);
    chk("rst_hold_out_data",  64'($unsigned(out_data)), 64'd0);
    chk("rst_hold_out_idx",   64'(out_idx),   64'd0);
    void'(q.pop_back());
    exp_idx   = 4'd0;
    out_ready = 1'b1;
    #1 rst = 1'b0;
    @(negedge clk);

    // Reset mid-group discards the partial sum
    send(ONE);
    send(ONE);
    #1 rst = 1'b1;
    #1;
    chk("rst_mid_in_ready", 64'(in_ready), 64'd1);
    #1 rst = 1'b0;
    exp_idx = 4'd0;
    @(negedge clk);
    group(ONE, ONE, ONE, ONE, 32'h0004_0000, 1'b0);

    n = 0;
    while (q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("queue_drained", 64'(q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
